serial_cond_subtractor: RTL and testbench
=========================================

Name: serial_cond_subtractor

Overview:
- Downstream partner of the serial digit comparator in the fp_sub_and_add path.
- Receives the same LSB-first digit stream of operands A and B that feeds the comparator. While the stream arrives, it serially computes A−B with a borrow chain and buffers both A and A−B.
- When the comparator reports (done, a_bigger_than_b), it streams out A−B if A>B, else A, one digit per handshake. This provides the final conditional reduction step.

Parameters:
- RADIX, 32, digit width in bits
- DIGITS, 14, digits per operand; streams are LSB first

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- start  in  1  one-cycle pulse that opens a new operation; honoured only in IDLE
- digit_valid  in  1  qualifies digit_a/digit_b; the same strobe drives the comparator
- digit_a  in  RADIX  digit of A
- digit_b  in  RADIX  digit of B
- cmp_done  in  1  comparator done pulse
- cmp_a_bigger  in  1  comparator a_bigger_than_b; sampled only when cmp_done=1
- res_ready  in  1  downstream accepts res_digit
- res_valid  out  RADIX-wide data qualifier, 1 bit  output digit valid
- res_digit  out  RADIX  result digit, LSB first
- res_last  out  1  high with the final digit (index DIGITS-1)
- subtracted  out  1  registered decision: 1 means the output is A−B; held until the next start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the cycle after the last digit handshake

Behaviour:
- Reset values:
  - res_valid=0, res_digit=0, res_last=0, subtracted=0, busy=0, done=0.
  - FSM goes to IDLE; counters, borrow and decision-pending flag are cleared.
  - Buffer contents need not be cleared.
- A reset asserted mid-operation aborts at once. No partial result or done pulse follows.
- FSM states: IDLE, LOAD, WAIT_CMP, OUT.
- IDLE:
  - start=1 moves to LOAD; wr_cnt=0, borrow=0, dec_pending=0.
  - A digit_valid arriving in the same cycle as start is accepted as digit 0, matching the comparator's start|running behaviour.
  - digit_valid without a preceding start is ignored.
- LOAD, on each cycle with digit_valid:
  - abuf[wr_cnt] ← digit_a.
  - {b_out, d} = {1'b0,digit_a} − {1'b0,digit_b} − borrow, computed at RADIX+1 bits; dbuf[wr_cnt] ← d[RADIX-1:0]; borrow ← b_out.
  - wr_cnt increments.
  - After digit DIGITS-1 is written, move to WAIT_CMP. Any further digit_valid is ignored until the next start.
  - digit_valid gaps are allowed; the state holds.
- cmp_done handling:
  - cmp_done is sampled in LOAD and WAIT_CMP. When it is 1, subtracted ← cmp_a_bigger and dec_pending ← 1.
  - The comparator's done normally arrives 2 cycles after the last digit. An early or coincident pulse is still captured.
  - A cmp_done pulse in IDLE or OUT is ignored.
- WAIT_CMP → OUT once dec_pending=1 and the load is complete. rd_cnt=0.
- OUT:
  - res_digit = subtracted ? dbuf[rd_cnt] : abuf[rd_cnt]; res_valid=1.
  - Outputs are registered. First res_valid appears 1 cycle after the OUT transition.
  - On res_valid & res_ready, rd_cnt increments and the next digit is presented the following cycle. The sustained rate is 1 digit/cycle.
  - res_last=1 while rd_cnt==DIGITS-1.
  - While res_valid=1 and res_ready=0, res_digit and res_last stay stable.
  - After the last handshake: res_valid←0, done←1 for one cycle, busy←0, return to IDLE.
- start while busy is ignored.
- The internal final borrow is kept only for assertion: when subtracted=1 it must be 0, since A>B implies no borrow.
- Latency: last input digit to first res_valid is 4 cycles with ready held high (comparator 2 + capture 1 + output register 1).

Decomposition:
- Shared package:
  - digit_t typedef (RADIX bits).
  - Index width `CLOG2(DIGITS).
  - FSM state encoding.
- One natural sub-module: serial_borrow_sub. It holds the registered borrow plus the RADIX+1-bit difference with enable and clear, and is reusable by the serial adder.
- The abuf and dbuf buffers are plain register arrays in the top module. There are two DIGITS×RADIX arrays and a single read mux.

Test Plan (RADIX=8, DIGITS=4):
- Basic subtract:
  - Stimulus: A=05,00,00,01 (MSB..LSB), B=04,FF,FF,FF, comparator done with a_bigger=1.
  - Response: out digits 02,00,00,00 LSB first; subtracted=1; res_last on 4th digit; done pulse.
- No subtract:
  - Stimulus: A=B=12,34,56,78, a_bigger=0.
  - Response: out 78,56,34,12; subtracted=0.
- Backpressure:
  - Stimulus: same as the basic-subtract scenario with res_ready low for 3 cycles at digit 1.
  - Response: digit 00 is held stable and no digit is dropped or duplicated.
- Early decision:
  - Stimulus: cmp_done coincident with digit 3.
  - Response: decision captured and output proceeds without waiting.
- Input gaps and extras:
  - Stimulus: digit_valid gaps between digits, plus a 5th digit_valid after the load.
  - Response: the 5th digit is ignored; result is correct.
- Reset abort:
  - Stimulus: rst asserted in OUT after digit 1.
  - Response: next cycle res_valid=0, busy=0, no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/serial_cond_subtractor_pkg.sv
// Shared types and constants for the serial conditional subtractor and its borrow-chain slice.
// Digit streams are LSB first; widths default to the fp_sub_and_add datapath.
package serial_cond_subtractor_pkg;

    localparam int DEF_RADIX  = 32;
    localparam int DEF_DIGITS = 14;

    typedef logic [DEF_RADIX-1:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_WAIT_CMP = 2'd2,
        ST_OUT      = 2'd3
    } state_t;

    // Index width that still works for a single-digit operand.
    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/serial_borrow_sub.sv
// One digit of a serial subtractor: combinational RADIX+1-bit difference with a registered borrow.
// clr forces a zero borrow-in, so a digit presented together with clr starts a fresh chain.
module serial_borrow_sub #(
    parameter int RADIX = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [RADIX-1:0] a,
    input  logic [RADIX-1:0] b,
    output logic [RADIX-1:0] diff,
    output logic             borrow
);

    logic             borrow_r;
    logic             borrow_in_s;
    logic [RADIX:0]   full_s;

    // Difference of the current digit pair including the incoming borrow.
    always_comb begin
        borrow_in_s = clr ? 1'b0 : borrow_r;
        full_s      = {1'b0, a} - {1'b0, b} - {{RADIX{1'b0}}, borrow_in_s};
    end

    // Borrow register: advances on each accepted digit, cleared when a new chain opens.
    always_ff @(posedge clk) begin
        if (rst) begin
            borrow_r <= 1'b0;
        end else if (en) begin
            borrow_r <= full_s[RADIX];
        end else if (clr) begin
            borrow_r <= 1'b0;
        end else begin
            borrow_r <= borrow_r;
        end
    end

    assign diff   = full_s[RADIX-1:0];
    assign borrow = borrow_r;

endmodule

// File: rtl/serial_cond_subtractor_chk.sv
// Checker: A>B can never leave a borrow out of the top digit of A-B.
module serial_cond_subtractor_chk (
    input logic clk,
    input logic rst,
    input logic check_en,
    input logic subtracted,
    input logic final_borrow
);

    // Once the subtract decision is in force, the stored chain must have ended borrow-free.
    always @(posedge clk) begin
        if (!rst && check_en && subtracted) begin
            assert (!final_borrow);
        end
    end

endmodule

// File: rtl/serial_cond_subtractor.sv
// Buffers A and A-B from an LSB-first digit stream, then streams out A-B when the
// comparator reports A>B, otherwise A, one digit per handshake.
module serial_cond_subtractor
    import serial_cond_subtractor_pkg::*;
#(
    parameter int RADIX  = DEF_RADIX,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             digit_valid,
    input  logic [RADIX-1:0] digit_a,
    input  logic [RADIX-1:0] digit_b,
    input  logic             cmp_done,
    input  logic             cmp_a_bigger,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [RADIX-1:0] res_digit,
    output logic             res_last,
    output logic             subtracted,
    output logic             busy,
    output logic             done
);

    localparam int             IDX_W    = idx_width(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   wr_cnt_r, rd_cnt_r;
    logic [IDX_W-1:0]   wr_idx_s, rd_nxt_s;
    logic               dec_pending_r, subtracted_r;
    logic               res_valid_r, res_last_r, busy_r, done_r;
    logic [RADIX-1:0]   res_digit_r;
    logic [RADIX-1:0]   abuf_r [DIGITS];
    logic [RADIX-1:0]   dbuf_r [DIGITS];
    logic               open_s, load_fire_s, cmp_take_s, finish_s;
    logic [RADIX-1:0]   diff_s, sel_digit_s;
    logic               final_borrow_s;

    serial_borrow_sub #(.RADIX(RADIX)) u_sub (
        .clk    (clk),
        .rst    (rst),
        .clr    (open_s),
        .en     (load_fire_s),
        .a      (digit_a),
        .b      (digit_b),
        .diff   (diff_s),
        .borrow (final_borrow_s)
    );

    serial_cond_subtractor_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .check_en     (state_r == ST_OUT),
        .subtracted   (subtracted_r),
        .final_borrow (final_borrow_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle strobes; a digit arriving with start is digit 0.
    always_comb begin
        state_s     = state_r;
        open_s      = 1'b0;
        load_fire_s = 1'b0;
        wr_idx_s    = wr_cnt_r;
        rd_nxt_s    = rd_cnt_r;
        finish_s    = 1'b0;
        cmp_take_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    open_s      = 1'b1;
                    wr_idx_s    = '0;
                    load_fire_s = digit_valid;
                    state_s     = (digit_valid && (LAST_IDX == '0)) ? ST_WAIT_CMP : ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_fire_s = digit_valid;
                cmp_take_s  = cmp_done;
                if (digit_valid && (wr_cnt_r == LAST_IDX)) begin
                    state_s = ST_WAIT_CMP;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_WAIT_CMP: begin
                cmp_take_s = cmp_done;
                if (dec_pending_r) begin
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_WAIT_CMP;
                end
            end
            ST_OUT: begin
                if (res_valid_r && res_ready) begin
                    if (rd_cnt_r == LAST_IDX) begin
                        finish_s = 1'b1;
                        state_s  = ST_IDLE;
                    end else begin
                        rd_nxt_s = rd_cnt_r + ONE_IDX;
                    end
                end else begin
                    rd_nxt_s = rd_cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        sel_digit_s = subtracted_r ? dbuf_r[rd_nxt_s] : abuf_r[rd_nxt_s];
    end

    // Operand and difference buffers; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (load_fire_s) begin
            abuf_r[wr_idx_s] <= digit_a;
            dbuf_r[wr_idx_s] <= diff_s;
        end
    end

    // Counters, decision capture and the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r      <= '0;
            rd_cnt_r      <= '0;
            dec_pending_r <= 1'b0;
            subtracted_r  <= 1'b0;
            res_valid_r   <= 1'b0;
            res_digit_r   <= '0;
            res_last_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            if (load_fire_s) begin
                wr_cnt_r <= wr_idx_s + ONE_IDX;
            end else if (open_s) begin
                wr_cnt_r <= '0;
            end else begin
                wr_cnt_r <= wr_cnt_r;
            end
            if (open_s) begin
                dec_pending_r <= 1'b0;
                subtracted_r  <= 1'b0;
            end else if (cmp_take_s) begin
                dec_pending_r <= 1'b1;
                subtracted_r  <= cmp_a_bigger;
            end else begin
                dec_pending_r <= dec_pending_r;
                subtracted_r  <= subtracted_r;
            end
            if (state_r == ST_OUT) begin
                rd_cnt_r    <= rd_nxt_s;
                res_valid_r <= !finish_s;
                res_last_r  <= !finish_s && (rd_nxt_s == LAST_IDX);
                res_digit_r <= finish_s ? res_digit_r : sel_digit_s;
            end else begin
                rd_cnt_r    <= '0;
                res_valid_r <= 1'b0;
                res_last_r  <= 1'b0;
                res_digit_r <= res_digit_r;
            end
            busy_r <= (state_s != ST_IDLE);
            done_r <= finish_s;
        end
    end

    assign res_valid  = res_valid_r;
    assign res_digit  = res_digit_r;
    assign res_last   = res_last_r;
    assign subtracted = subtracted_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_serial_cond_subtractor.sv
// Randomised self-checking bench: whole-word reference (A>B ? A-B : A) against the digit stream,
// plus directed scenarios with hand-computed results.
module tb_serial_cond_subtractor;

    localparam int RADIX  = 8;
    localparam int DIGITS = 4;

    logic             clk = 1'b0;
    logic             rst, start, digit_valid, cmp_done, cmp_a_bigger, res_ready;
    logic [RADIX-1:0] digit_a, digit_b, res_digit;
    logic             res_valid, res_last, subtracted, busy, done;

    int          n_tests = 0, n_fail = 0, cyc = 0;
    int          out_idx, done_cnt, first_valid_cyc, drive_cyc, ready_mode, stall_cnt;
    logic [31:0] exp_word, col_word;
    logic        exp_sub, prev_hold, prev_last;
    logic [7:0]  prev_digit;

    always #5 clk = ~clk;

    serial_cond_subtractor #(.RADIX(RADIX), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .digit_valid(digit_valid),
        .digit_a(digit_a), .digit_b(digit_b), .cmp_done(cmp_done),
        .cmp_a_bigger(cmp_a_bigger), .res_ready(res_ready), .res_valid(res_valid),
        .res_digit(res_digit), .res_last(res_last), .subtracted(subtracted),
        .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: always, random, or a 3-cycle stall on digit 1.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: res_ready = 1'($urandom_range(0, 1));
            2: begin
                if (res_valid && out_idx == 1 && stall_cnt < 3) begin
                    res_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    res_ready = 1'b1;
                end
            end
            default: res_ready = 1'b1;
        endcase
    end

    // Compare process: every visible digit against the reference word.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", res_valid, 1);
                check("hold_digit", res_digit, prev_digit);
                check("hold_last", res_last, prev_last);
            end
            if (res_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_idx >= DIGITS) begin
                    check("extra_digit", out_idx, DIGITS - 1);
                end else begin
                    check("res_digit", res_digit, exp_word[RADIX*out_idx +: RADIX]);
                    check("res_last", res_last, (out_idx == DIGITS - 1));
                    check("subtracted", subtracted, exp_sub);
                    if (res_ready) begin
                        col_word[RADIX*out_idx +: RADIX] = res_digit;
                        out_idx++;
                    end
                end
                prev_hold  = !res_ready;
                prev_digit = res_digit;
                prev_last  = res_last;
            end else begin
                prev_hold = 1'b0;
            end
            if (done) begin
                check("done_after_last", out_idx, DIGITS);
                done_cnt++;
            end
        end
    end

    task automatic idle_inputs();
        digit_valid  = 1'b0;
        start        = 1'b0;
        cmp_done     = 1'b0;
        cmp_a_bigger = 1'($urandom_range(0, 1));
        digit_a      = 8'($urandom);
        digit_b      = 8'($urandom);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int cmp_dly,
                          input int gap_max, input bit same_cyc, input bit extra, input bit abort);
        logic a_big;
        int   t;
        a_big           = (a > b);
        exp_word        = a_big ? (a - b) : a;
        exp_sub         = a_big;
        out_idx         = 0;
        col_word        = 32'h0;
        done_cnt        = 0;
        first_valid_cyc = -1;
        stall_cnt       = 0;
        @(posedge clk); #1;
        start = 1'b1;
        if (same_cyc) begin
            digit_valid = 1'b1;
            digit_a     = a[7:0];
            digit_b     = b[7:0];
        end
        @(posedge clk); #1;
        idle_inputs();
        check("busy_after_start", busy, 1);
        for (int i = (same_cyc ? 1 : 0); i < DIGITS; i++) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            digit_valid = 1'b1;
            digit_a     = a[RADIX*i +: RADIX];
            digit_b     = b[RADIX*i +: RADIX];
            if (i == DIGITS - 1) begin
                drive_cyc = cyc;
                if (cmp_dly == 0) begin
                    cmp_done     = 1'b1;
                    cmp_a_bigger = a_big;
                end
            end
            @(posedge clk); #1;
            idle_inputs();
        end
        for (int k = 1; k <= cmp_dly; k++) begin
            if (k == 1 && extra) begin
                digit_valid = 1'b1;
                start       = 1'b1;
            end
            if (k == cmp_dly) begin
                cmp_done     = 1'b1;
                cmp_a_bigger = a_big;
            end
            @(posedge clk); #1;
            idle_inputs();
        end
        if (abort) begin
            t = 0;
            while (out_idx < 2 && t < 100) begin @(negedge clk); #1; t++; end
            check("abort_reached_digit1", (out_idx >= 2), 1);
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("abort_valid", res_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            rst = 1'b0;
            repeat (6) @(negedge clk);
            #1;
            check("abort_no_done", done_cnt, 0);
        end else begin
            t = 0;
            while (done_cnt == 0 && t < 300) begin @(negedge clk); #1; t++; end
            check("done_seen", done_cnt, 1);
            check("result_word", col_word, exp_word);
            check("busy_at_done", busy, 0);
            if (cmp_dly == 2) check("latency", first_valid_cyc - drive_cyc - 1, 4);
            @(negedge clk); #1;
            check("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          cd;
        rst = 1'b1; ready_mode = 0; res_ready = 1'b1;
        out_idx = 0; done_cnt = 0; first_valid_cyc = -1; stall_cnt = 0;
        exp_word = 32'h0; col_word = 32'h0; exp_sub = 1'b0; prev_hold = 1'b0;
        prev_digit = 8'h0; prev_last = 1'b0; drive_cyc = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_digit", res_digit, 0);
        check("rst_res_last", res_last, 0);
        check("rst_subtracted", subtracted, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Digit stream with no start must not wake the block.
        @(posedge clk); #1;
        digit_valid = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        check("no_start_busy", busy, 0);

        run_op(32'h05000001, 32'h04FFFFFF, 2, 0, 1'b1, 1'b0, 1'b0);
        check("basic_word", col_word, 32'h00000002);
        check("basic_sub_held", subtracted, 1);

        run_op(32'h12345678, 32'h12345678, 2, 0, 1'b0, 1'b0, 1'b0);
        check("nosub_word", col_word, 32'h12345678);
        check("nosub_sub", subtracted, 0);

        ready_mode = 2;
        run_op(32'h05000001, 32'h04FFFFFF, 2, 0, 1'b1, 1'b0, 1'b0);
        check("bp_word", col_word, 32'h00000002);
        check("bp_stalls", stall_cnt, 3);
        ready_mode = 0;

        run_op(32'h05000001, 32'h04FFFFFF, 0, 0, 1'b0, 1'b0, 1'b0);
        check("early_word", col_word, 32'h00000002);

        run_op(32'h9ABCDEF0, 32'h12345678, 2, 3, 1'b0, 1'b1, 1'b0);
        check("gaps_word", col_word, 32'h88888878);

        run_op(32'h05000001, 32'h04FFFFFF, 2, 0, 1'b1, 1'b0, 1'b1);
        run_op(32'h05000001, 32'h04FFFFFF, 2, 0, 1'b1, 1'b0, 1'b0);
        check("after_abort_word", col_word, 32'h00000002);

        ready_mode = 1;
        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0:       rb = $urandom;
                1:       rb = ra;
                default: rb = ra - $urandom_range(0, 300);
            endcase
            cd = $urandom_range(0, 3);
            run_op(ra, rb, cd, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                   (cd > 0) && ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
